uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter BYTE_ADDR_WIDTH, default 10: width of the program-memory byte address (1 KiB).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: maximum number of idle clocks allowed between bytes inside a frame.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5: the frame start marker.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic SHALL be rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8: the received UART byte.
REQ-007 SHALL have port rx_valid, input, 1: a one-cycle pulse marking rx_data valid.
REQ-008 SHALL have port byte_addr_out, output, BYTE_ADDR_WIDTH: the byte address of the write, feeding the byte-to-word lane stage.
REQ-009 SHALL have port byte_data_out, output, 8: the write data byte.
REQ-010 SHALL have port byte_wr_en_out, output, 1: a one-cycle write strobe.
REQ-011 SHALL have port cpu_rst_n_out, output, 1: the core reset; low holds the CPU in reset.
REQ-012 SHALL have port load_done, output, 1: a one-cycle pulse on successful load.
REQ-013 SHALL have port load_err, output, 1: sticky error flag.

Function
REQ-014 Frame format SHALL be SYNC_BYTE, then a 32-bit byte count LEN (little-endian, 4 bytes), then LEN payload bytes.
REQ-015 States SHALL be IDLE, LEN (2-bit byte index), DATA, DONE.
REQ-016 In IDLE, an rx_valid with rx_data==SYNC_BYTE SHALL transition to LEN, drive cpu_rst_n_out low, clear load_err, and clear the address counter; any other byte SHALL be ignored.
REQ-017 In LEN, each rx_valid SHALL shift its byte into length bits [8*i+7:8*i]; after the 4th byte, control SHALL evaluate the length (REQ-018 to REQ-020).
REQ-018 If LEN==0, the next state SHALL be DONE.
REQ-019 If LEN>2**BYTE_ADDR_WIDTH, the block SHALL set load_err, go to IDLE, and keep cpu_rst_n_out low.
REQ-020 Otherwise the next state SHALL be DATA, with remaining count = LEN.
REQ-021 In DATA, each rx_valid SHALL register byte_addr_out=addr and byte_data_out=rx_data, and assert byte_wr_en_out in the next cycle. Latency SHALL be exactly 1 clock from rx_valid.
REQ-022 After each write, addr SHALL increment by 1 and the count SHALL decrement by 1.
REQ-023 Writing at the last address (2**BYTE_ADDR_WIDTH-1) SHALL be legal and SHALL be followed by DONE, with no address wrap-around.
REQ-024 When the remaining count reaches 0, the next state SHALL be DONE.
REQ-025 DONE SHALL last exactly 1 cycle, coinciding with or after the final byte_wr_en_out: load_done=1 and cpu_rst_n_out goes high in the same cycle; the next state SHALL be IDLE.
REQ-026 The timeout counter SHALL reset on every rx_valid and on entry to LEN.
REQ-027 In LEN or DATA, reaching TIMEOUT_CYCLES without rx_valid SHALL set load_err and go to IDLE; cpu_rst_n_out SHALL stay low.
REQ-028 The timeout counter SHALL be inactive in IDLE and DONE.
REQ-029 An rx_valid in DONE SHALL be processed as if in IDLE, so a SYNC_BYTE there starts a new frame.
REQ-030 Re-sync SHALL be disallowed mid-frame: SYNC_BYTE inside LEN or DATA is data.
REQ-031 byte_wr_en_out SHALL never assert outside DATA-driven writes.
REQ-032 byte_addr_out and byte_data_out SHALL hold their last values when not writing.

Reset
REQ-033 On rst_n low, all outputs SHALL respond immediately: state=IDLE, byte_addr_out=0, byte_data_out=0, byte_wr_en_out=0, load_done=0, load_err=0, cpu_rst_n_out=0, counters=0.
REQ-034 Reset mid-frame SHALL abandon the frame, with no further writes.
REQ-035 cpu_rst_n_out SHALL remain 0 after reset until the first successful load.

Structure
REQ-036 Shared package SHALL hold the state encoding constants, the SYNC_BYTE default, and the header length (4).
REQ-037 The timeout counter SHALL be a natural sub-module, gap_timer (clear, enable, expired), sized $clog2(TIMEOUT_CYCLES+1).
REQ-038 The implementation SHALL be one FSM with registered outputs and no combinational output paths from rx inputs.

Verification
REQ-039 Bench SHALL cover A5,04,00,00,00,11,22,33,44 -> writes (0,11),(1,22),(2,33),(3,44), each 1 clk after rx_valid; load_done one pulse; cpu_rst_n_out rises with it.
REQ-040 Bench SHALL cover A5,00,00,00,00 -> no writes; load_done pulse; cpu_rst_n_out=1.
REQ-041 Bench SHALL cover BYTE_ADDR_WIDTH=10, LEN=1025 -> load_err=1, IDLE, no writes, cpu_rst_n_out=0; LEN=1024 -> last write at addr 0x3FF, then load_done.
REQ-042 Bench SHALL cover TIMEOUT_CYCLES=100, header LEN=4, 2 payload bytes then silence -> load_err at gap cycle 100, IDLE, subsequent good frame clears load_err.
REQ-043 Bench SHALL cover stray bytes 00,FF before A5, and A5 inside payload -> ignored in IDLE and written as data in DATA.
REQ-044 Bench SHALL cover rst_n pulsed low after the 2nd payload byte -> outputs at reset values asynchronously, no further writes, new frame loads from addr 0.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Frame: sync byte, 4-byte little-endian length, payload.
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         HDR_LEN       = 4;

endpackage

// File: rtl/uart_prog_loader_gap_timer.sv
// Idle-gap watchdog between received bytes.
// Counts only while enabled; any clear or disable restarts it.
module uart_prog_loader_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (clear || !enable)
      r_cnt <= '0;
    else if (!expired)
      r_cnt <= r_cnt + 1'b1;
  end

  assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: parses a sync/length/payload frame into byte
// writes and holds the CPU in reset until a frame loads cleanly.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int         BYTE_ADDR_WIDTH = 10,
  parameter int         TIMEOUT_CYCLES  = 1_000_000,
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [BYTE_ADDR_WIDTH-1:0] byte_addr_out,
  output logic [7:0]                 byte_data_out,
  output logic                       byte_wr_en_out,
  output logic                       cpu_rst_n_out,
  output logic                       load_done,
  output logic                       load_err
);

  localparam int          AW      = BYTE_ADDR_WIDTH;
  localparam int          CW      = BYTE_ADDR_WIDTH + 1;
  localparam logic [32:0] MAX_LEN = 33'd1 << BYTE_ADDR_WIDTH;
  localparam logic [1:0]  LAST_IX = 2'(HDR_LEN - 1);

  state_t        r_state, w_next;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [23:0]   r_len, w_len_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] w_oaddr_nxt;
  logic [7:0]    w_odata_nxt;
  logic          w_wr_nxt, w_done_nxt, w_err_nxt, w_cpu_nxt;

  logic [31:0]   w_len_full;
  logic          w_len_zero, w_len_big, w_sync;
  logic          w_active, w_expired;

  assign w_len_full = {rx_data, r_len};
  assign w_len_zero = (w_len_full == 32'd0);
  assign w_len_big  = ({1'b0, w_len_full} > MAX_LEN);
  assign w_sync     = rx_valid && (rx_data == SYNC_BYTE);
  assign w_active   = (r_state == ST_LEN) || (r_state == ST_DATA);

  uart_prog_loader_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid),
    .enable (w_active),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_len          <= '0;
      r_addr         <= '0;
      r_cnt          <= '0;
      byte_addr_out  <= '0;
      byte_data_out  <= '0;
      byte_wr_en_out <= 1'b0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
      cpu_rst_n_out  <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_idx          <= w_idx_nxt;
      r_len          <= w_len_nxt;
      r_addr         <= w_addr_nxt;
      r_cnt          <= w_cnt_nxt;
      byte_addr_out  <= w_oaddr_nxt;
      byte_data_out  <= w_odata_nxt;
      byte_wr_en_out <= w_wr_nxt;
      load_done      <= w_done_nxt;
      load_err       <= w_err_nxt;
      cpu_rst_n_out  <= w_cpu_nxt;
    end
  end

  // A received byte always wins over a same-cycle timeout.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE:
        w_next = w_sync ? ST_LEN : ST_IDLE;
      ST_LEN:
        if (rx_valid) begin
          if (r_idx == LAST_IX) begin
            if (w_len_zero)     w_next = ST_DONE;
            else if (w_len_big) w_next = ST_IDLE;
            else                w_next = ST_DATA;
          end
        end else if (w_expired) begin
          w_next = ST_IDLE;
        end
      ST_DATA:
        if (rx_valid) begin
          if (r_cnt == CW'(1)) w_next = ST_DONE;
        end else if (w_expired) begin
          w_next = ST_IDLE;
        end
      default:
        w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_oaddr_nxt = byte_addr_out;
    w_odata_nxt = byte_data_out;
    w_wr_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = load_err;
    w_cpu_nxt   = cpu_rst_n_out;
    unique case (r_state)
      ST_IDLE, ST_DONE:
        if (w_sync) begin
          w_idx_nxt  = '0;
          w_len_nxt  = '0;
          w_addr_nxt = '0;
          w_err_nxt  = 1'b0;
          w_cpu_nxt  = 1'b0;
        end
      ST_LEN:
        if (rx_valid) begin
          w_idx_nxt = r_idx + 1'b1;
          unique case (1'b1)
            (r_idx == 2'd0): w_len_nxt[7:0]   = rx_data;
            (r_idx == 2'd1): w_len_nxt[15:8]  = rx_data;
            (r_idx == 2'd2): w_len_nxt[23:16] = rx_data;
            default: ;
          endcase
          if (r_idx == LAST_IX) begin
            if (w_len_zero) begin
              w_done_nxt = 1'b1;
              w_cpu_nxt  = 1'b1;
            end else if (w_len_big) begin
              w_err_nxt = 1'b1;
            end else begin
              w_cnt_nxt = w_len_full[CW-1:0];
            end
          end
        end else if (w_expired) begin
          w_err_nxt = 1'b1;
        end
      ST_DATA:
        if (rx_valid) begin
          w_oaddr_nxt = r_addr;
          w_odata_nxt = rx_data;
          w_wr_nxt    = 1'b1;
          w_addr_nxt  = r_addr + 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            w_done_nxt = 1'b1;
            w_cpu_nxt  = 1'b1;
          end
        end else if (w_expired) begin
          w_err_nxt = 1'b1;
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with hand-computed frames.
// Inputs and checks on the falling edge; writes logged by a monitor.
module tb_uart_prog_loader;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] byte_addr_out;
  logic [7:0] byte_data_out;
  logic       byte_wr_en_out;
  logic       cpu_rst_n_out;
  logic       load_done;
  logic       load_err;

  int n_chk  = 0;
  int n_err  = 0;
  int n_done = 0;
  logic [9:0] wa[$];
  logic [7:0] wd[$];

  always #5 clk = ~clk;

  uart_prog_loader #(
    .BYTE_ADDR_WIDTH(10),
    .TIMEOUT_CYCLES (100),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .byte_addr_out (byte_addr_out),
    .byte_data_out (byte_data_out),
    .byte_wr_en_out(byte_wr_en_out),
    .cpu_rst_n_out (cpu_rst_n_out),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  always @(negedge clk) begin
    if (byte_wr_en_out) begin
      wa.push_back(byte_addr_out);
      wd.push_back(byte_data_out);
    end
    if (load_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    wa.delete();
    wd.delete();
    n_done = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] len);
    send_byte(8'hA5);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    send_byte(len[23:16]);
    send_byte(len[31:24]);
  endtask

  task automatic send_chk(input logic [7:0] b, input logic [9:0] a,
                          input logic last);
    send_byte(b);
    chk($sformatf("wr@%0h", a), 32'(byte_wr_en_out), 32'd1);
    chk($sformatf("addr@%0h", a), 32'(byte_addr_out), 32'(a));
    chk($sformatf("data@%0h", a), 32'(byte_data_out), 32'(b));
    chk($sformatf("done@%0h", a), 32'(load_done), 32'(last));
    chk($sformatf("cpu@%0h", a), 32'(cpu_rst_n_out), 32'(last));
  endtask

  initial begin
    int bad;
    #3;
    chk("rst_wr",   32'(byte_wr_en_out), 32'd0);
    chk("rst_addr", 32'(byte_addr_out),  32'd0);
    chk("rst_data", 32'(byte_data_out),  32'd0);
    chk("rst_done", 32'(load_done),      32'd0);
    chk("rst_err",  32'(load_err),       32'd0);
    chk("rst_cpu",  32'(cpu_rst_n_out),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_log();

    // basic 4-byte frame
    send_hdr(32'd4);
    chk("t1_cpu_lo", 32'(cpu_rst_n_out), 32'd0);
    send_chk(8'h11, 10'd0, 1'b0);
    send_chk(8'h22, 10'd1, 1'b0);
    send_chk(8'h33, 10'd2, 1'b0);
    send_chk(8'h44, 10'd3, 1'b1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(load_done),      32'd0);
    chk("t1_wr_off",     32'(byte_wr_en_out), 32'd0);
    chk("t1_cpu_hi",     32'(cpu_rst_n_out),  32'd1);
    chk("t1_addr_hold",  32'(byte_addr_out),  32'h3);
    chk("t1_data_hold",  32'(byte_data_out),  32'h44);
    chk("t1_nwr",   32'(wa.size()), 32'd4);
    chk("t1_ndone", 32'(n_done),    32'd1);
    clr_log();

    // zero-length frame
    send_byte(8'hA5);
    chk("t2_cpu_lo", 32'(cpu_rst_n_out), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("t2_done", 32'(load_done),     32'd1);
    chk("t2_cpu",  32'(cpu_rst_n_out), 32'd1);
    @(negedge clk);
    chk("t2_nwr",   32'(wa.size()), 32'd0);
    chk("t2_ndone", 32'(n_done),    32'd1);
    clr_log();

    // oversize frame, then stray byte in IDLE
    send_hdr(32'd1025);
    chk("t3_err", 32'(load_err),      32'd1);
    chk("t3_cpu", 32'(cpu_rst_n_out), 32'd0);
    send_byte(8'h11);
    chk("t3_idle_wr", 32'(byte_wr_en_out), 32'd0);
    @(negedge clk);
    chk("t3_nwr", 32'(wa.size()), 32'd0);
    chk("t3_ndone", 32'(n_done), 32'd0);
    clr_log();

    // full 1 KiB frame
    send_hdr(32'd1024);
    chk("t3b_err_clr", 32'(load_err), 32'd0);
    for (int i = 0; i < 1023; i++) send_byte(8'(i));
    send_chk(8'hFF, 10'h3FF, 1'b1);
    @(negedge clk);
    chk("t3b_nowrap", 32'(byte_wr_en_out), 32'd0);
    chk("t3b_nwr", 32'(wa.size()), 32'd1024);
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 10'(i) || wd[i] !== 8'(i)) bad++;
    chk("t3b_seq", 32'(bad), 32'd0);
    chk("t3b_ndone", 32'(n_done), 32'd1);
    clr_log();

    // inter-byte timeout, then recovery
    send_hdr(32'd4);
    send_byte(8'hC1);
    send_byte(8'hC2);
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("t4_err_99", 32'(load_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_err_100", 32'(load_err),      32'd1);
    chk("t4_cpu",     32'(cpu_rst_n_out), 32'd0);
    send_byte(8'h33);
    chk("t4_idle_wr", 32'(byte_wr_en_out), 32'd0);
    chk("t4_nwr", 32'(wa.size()), 32'd2);
    clr_log();
    send_byte(8'hA5);
    chk("t4_err_clr", 32'(load_err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_chk(8'h77, 10'd0, 1'b1);
    @(negedge clk);
    clr_log();

    // stray bytes before sync, sync value inside payload
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("t5_stray_wr", 32'(byte_wr_en_out), 32'd0);
    chk("t5_cpu_keep", 32'(cpu_rst_n_out),  32'd1);
    send_hdr(32'd3);
    send_chk(8'hA5, 10'd0, 1'b0);
    send_chk(8'h10, 10'd1, 1'b0);
    send_chk(8'hA5, 10'd2, 1'b1);
    @(negedge clk);
    chk("t5_nwr", 32'(wa.size()), 32'd3);
    clr_log();

    // asynchronous reset mid-frame
    send_hdr(32'd4);
    send_chk(8'h5C, 10'd0, 1'b0);
    send_chk(8'h6D, 10'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_wr",   32'(byte_wr_en_out), 32'd0);
    chk("t6_addr", 32'(byte_addr_out),  32'd0);
    chk("t6_data", 32'(byte_data_out),  32'd0);
    chk("t6_cpu",  32'(cpu_rst_n_out),  32'd0);
    chk("t6_err",  32'(load_err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_log();
    send_byte(8'h7E);
    send_byte(8'h8F);
    chk("t6_nwr", 32'(wa.size()), 32'd0);
    send_hdr(32'd2);
    send_chk(8'h5A, 10'd0, 1'b0);
    send_chk(8'h6B, 10'd1, 1'b1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
